// File: rtl/prio_arbiter_pkg.sv
// Shared types for the registered N-way priority / round-robin arbiter.
package arb_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesting channels (master) and the arbiter (slave).
interface prio_arbiter_if #(parameter int N = 8);
  import arb_pkg::*;

  localparam int IDXW = $clog2(N);

  logic [N-1:0]    req;
  arb_mode_e       mode;
  logic            gnt_ready;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic [N-1:0]    gnt_onehot;

  modport master (output req, mode, gnt_ready, input gnt_valid, gnt_idx, gnt_onehot);
  modport slave  (input req, mode, gnt_ready, output gnt_valid, gnt_idx, gnt_onehot);

endinterface

// File: rtl/prio_arbiter_pri_enc_n.sv
// Combinational N-input encoder: reports the highest set index and whether any bit is set.
module pri_enc_n #(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    in,
  output logic [IDXW-1:0] out,
  output logic            found
);

  always_comb begin
    out   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in[IDXW'(i)]) begin
        out   = IDXW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed (highest index wins) or round-robin, grant held until handshake.
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst_n,
  prio_arbiter_if.slave bus
);

  localparam int              IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  arb_state_e      state_q, state_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    oh_q, oh_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            hs;
  logic [IDXW-1:0] ptr_dec;
  logic [IDXW-1:0] top;
  logic [N-1:0]    req_rot;
  logic [IDXW-1:0] enc_idx;
  logic [IDXW-1:0] win_idx;
  logic            found;

  // Handshake moves the pointer first; re-arbitration in the same cycle uses the new value.
  always_comb begin
    hs      = (state_q == GRANT) && bus.gnt_ready;
    ptr_dec = (idx_q == '0) ? LAST : idx_q - 1'b1;
    ptr_d   = hs ? ptr_dec : ptr_q;
    top     = (bus.mode == ARB_RR) ? ptr_d : LAST;
  end

  // Rotate so the top-priority index lands on bit N-1; the encoder then picks the winner.
  always_comb begin
    req_rot = '0;
    for (int unsigned j = 0; j < N; j++) begin
      req_rot[IDXW'((j + N - 1 - 32'(top)) % N)] = bus.req[IDXW'(j)];
    end
  end

  pri_enc_n #(.N(N)) u_enc (
    .in    (req_rot),
    .out   (enc_idx),
    .found (found)
  );

  assign win_idx = IDXW'((32'(enc_idx) + 32'(top) + 1) % N);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          valid_d       = 1'b1;
          idx_d         = win_idx;
          oh_d          = '0;
          oh_d[win_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          if (found) begin
            valid_d       = 1'b1;
            idx_d         = win_idx;
            oh_d          = '0;
            oh_d[win_idx] = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
        oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= LAST;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = oh_q;

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered N-way arbiter that generalises the 4-input priority encoder. It supports fixed priority, where the highest index wins, and a round-robin mode. The winner is held stable under a valid/ready handshake, with a registered one-cycle grant path. It sits between request-raising channels and a shared downstream resource.

## Interface
- N, default 8: number of request channels, legal range 2..32.
- IDXW, default $clog2(N): localparam, index width, not overridable.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  N  request vector; bit i high means channel i requests.
- mode  input  1  0 = fixed priority (ARB_FIXED), 1 = round-robin (ARB_RR); sampled only when a new arbitration occurs.
- gnt_ready  input  1  downstream accepts the current grant.
- gnt_valid  output  1  a grant is being presented.
- gnt_idx  output  IDXW  index of the granted channel.
- gnt_onehot  output  N  one-hot of gnt_idx; all zero when gnt_valid=0.

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- Reset values: gnt_valid=0, gnt_idx=0, gnt_onehot=0, state=IDLE, ptr=N-1.
- Priority order is descending from a top index T, wrapping: T, T-1, …, 0, N-1, …, T+1.
  - Fixed mode: T = N-1, so the highest set bit wins, matching the legacy encoder.
  - RR mode: T = ptr.
- Arbitration takes the first set bit of req in that order. If req=0 there is no winner.
- State IDLE, selected when no grant is presented:
  - If req≠0, register the winner and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT, selected when gnt_valid=1:
  - gnt_idx and gnt_onehot are held stable while gnt_ready=0, even if the granted req bit drops. Grants are sticky; no revocation.
  - On handshake (gnt_valid & gnt_ready), ptr ← (gnt_idx−1) mod N. ptr is updated in both modes and used only in RR.
  - On handshake, re-arbitrate in the same cycle on the current req with the updated ptr:
    - Winner exists: stay in GRANT and load the new winner.
    - No winner: go to IDLE and clear the outputs.
- Back-to-back effect of the pointer update:
  - RR: the just-granted channel becomes lowest priority.
  - Fixed: the just-granted channel can win again.
- Wrap-around: a grant of index 0 sets ptr=N-1.
- A mode change while in GRANT does not disturb the held grant; it takes effect at the next arbitration.
- gnt_ready while gnt_valid=0 is ignored.
- Reset asserted mid-grant clears all state immediately. No handshake is reported.

## Timing
- req to gnt_valid: 1 cycle. req sampled at edge k gives a grant visible after edge k.
- Handshake at edge k gives the next grant (or gnt_valid=0) visible after edge k. Sustained throughput is one grant per cycle with gnt_ready tied high.
- All outputs come directly from flops; there is no combinational input-to-output path.
- req is not required to be held; only its value at the arbitration edge matters.

## Structure
- Package arb_pkg:
  - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
  - typedef enum logic {IDLE, GRANT} arb_state_e.
- Sub-module pri_enc_n: parametrised combinational highest-index-wins encoder.
  - Ports: in[N], out[IDXW], found.
  - found replaces the legacy valid output.
  - RR is implemented by rotating req by (N−1−ptr), encoding, then un-rotating the index mod N.
- Top: state register, ptr register, output registers, rotate/unrotate logic.

## Test plan
- Reset/idle: N=4, assert rst_n=0 mid-grant → outputs 0, ptr=3. Release with req=0 → gnt_valid stays 0.
- Fixed priority: N=4, mode=0, req=4'b0110, gnt_ready=1 held.
  - Expect gnt_idx=2, then 2 again every cycle while req is unchanged.
  - Drop req to 4'b0001 → gnt_idx=0.
- Round-robin fairness: N=4, mode=1, req=4'b1111, gnt_ready=1.
  - Expect gnt_idx sequence 3,2,1,0,3 on consecutive cycles.
  - Expect gnt_onehot to match each index.
- Hold under backpressure: N=4, req=4'b1000 for one cycle, gnt_ready=0 for 5 cycles.
  - Expect gnt_idx=3 and gnt_valid=1 stable throughout, despite req dropping.
  - Raise gnt_ready → next cycle gnt_valid=0.
- Mode switch and wrap: N=4.
  - mode=1: grant 0 then handshake → ptr=3.
  - Switch mode=0 during a held grant → held grant unchanged.
  - With req=4'b0011 → next grant is 1.
- Random regression: N=8, random req/mode/gnt_ready against a reference model. Check:
  - onehot/idx consistency.
  - No grant to an index with req=0 at its arbitration edge.
  - Stability while gnt_ready=0.
